rs232_rx: RTL and testbench

//   UART receive stage: deserialises an 8N1 RS232 line (idle-high, start bit 0,
//   8 data bits LSB first, 1 stop bit) into bytes. It is the far-end consumer of
//   the transmit block's serial output and pairs with it in loopback benches.

---
 rtl/rs232_rx.sv | 137 +++++++++++++
 tb/tb_rs232_rx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rs232_rx.sv
// rs232_rx: UART receive stage for an 8N1 line (idle high, start bit 0,
// eight data bits LSB first, one stop bit). Each good frame produces one
// data_valid pulse. Each low stop bit produces one frame_err pulse.
//
// Ports
//   sys_clk     in   1  single clock, rising edge
//   sys_rst     in   1  asynchronous, active-high reset
//   rx          in   1  asynchronous serial input, idle high
//   data_out    out  8  last correctly received byte, held until the next good frame
//   data_valid  out  1  one-cycle pulse when data_out is updated
//   frame_err   out  1  one-cycle pulse when the stop bit is sampled low
//   busy        out  1  high whenever the receiver is not idle
module rs232_rx #(
    parameter int CLK_DIV = 5208,   // sys_clk cycles per bit, >= 4
    parameter int CNT_W   = 13      // 2**CNT_W > CLK_DIV
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_DIV - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] baud_cnt, cnt_nx;
    logic [2:0]       bit_idx, idx_nx;
    logic [7:0]       shift, shift_nx;
    logic             rx_s1, rx_s, rx_d;
    logic             fall;
    logic             load, err;

    // Two-flop synchroniser plus a delay flop for edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s  <= rx_s1;
            rx_d  <= rx_s;
        end
    end

    assign fall = !rx_s && rx_d;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            baud_cnt   <= cnt_nx;
            bit_idx    <= idx_nx;
            shift      <= shift_nx;
            data_valid <= load;
            frame_err  <= err;
            if (load) data_out <= shift;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = baud_cnt;
        idx_nx   = bit_idx;
        shift_nx = shift;
        load     = 1'b0;
        err      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nx = '0;
                if (fall) state_nx = START;
            end
            START: begin
                // Re-check the line at mid start bit; a high level means the
                // edge was a glitch and the frame is abandoned silently.
                if (baud_cnt == HALF_M1) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = rx_s ? IDLE : DATA;
                end else begin
                    cnt_nx = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                // Counting starts at mid start bit, so a full period lands
                // on each data bit centre.
                if (baud_cnt == FULL_M1) begin
                    cnt_nx            = '0;
                    shift_nx[bit_idx] = rx_s;
                    idx_nx            = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end else begin
                    cnt_nx = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid stop bit so a start bit that follows with no
                // idle gap is still caught by the edge detector in IDLE.
                if (baud_cnt == FULL_M1) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        load     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        err      = 1'b1;
                        state_nx = BREAK;
                    end
                end else begin
                    cnt_nx = baud_cnt + 1'b1;
                end
            end
            BREAK: begin
                // Hold off until the line goes high so a stuck-low line
                // reports a single frame error.
                cnt_nx = '0;
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_rs232_rx.sv
// tb_rs232_rx: directed bench for rs232_rx. One instance runs at the
// production divisor (5208) for the idle and single-frame checks; a second
// instance at a short divisor (16) covers back-to-back frames, glitch
// rejection, stop-bit errors and mid-frame reset within a small cycle count.
module tb_rs232_rx;

    localparam int DIV_B = 5208;
    localparam int DIV_S = 16;
    localparam int PER   = 10;

    logic       sys_clk = 1'b0;
    logic       rst_b, rst_s;
    logic       rx_b, rx_s;
    logic [7:0] dout_b, dout_s;
    logic       dv_b, dv_s, fe_b, fe_s, busy_b, busy_s;

    int  vectors = 0;
    int  miscompares = 0;

    int      nv_b = 0, nfe_b = 0, nv_s = 0, nfe_s = 0;
    int      both_cnt = 0, wide_cnt = 0;
    logic    dv_b_q = 1'b0, dv_s_q = 1'b0, fe_b_q = 1'b0, fe_s_q = 1'b0;
    logic [7:0] q_s[$];
    longint  t_dv_b = 0, t_dv_s = 0;

    always #(PER/2) sys_clk = ~sys_clk;

    rs232_rx #(.CLK_DIV(DIV_B), .CNT_W(13)) u_big (
        .sys_clk(sys_clk), .sys_rst(rst_b), .rx(rx_b), .data_out(dout_b),
        .data_valid(dv_b), .frame_err(fe_b), .busy(busy_b));

    rs232_rx #(.CLK_DIV(DIV_S), .CNT_W(5)) u_sml (
        .sys_clk(sys_clk), .sys_rst(rst_s), .rx(rx_s), .data_out(dout_s),
        .data_valid(dv_s), .frame_err(fe_s), .busy(busy_s));

    // Pulse monitors, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (!rst_b) begin
            if (dv_b) begin nv_b++; t_dv_b = $time; end
            if (fe_b) nfe_b++;
            if (dv_b && fe_b) both_cnt++;
            if ((dv_b && dv_b_q) || (fe_b && fe_b_q)) wide_cnt++;
        end
        if (!rst_s) begin
            if (dv_s) begin nv_s++; q_s.push_back(dout_s); t_dv_s = $time; end
            if (fe_s) nfe_s++;
            if (dv_s && fe_s) both_cnt++;
            if ((dv_s && dv_s_q) || (fe_s && fe_s_q)) wide_cnt++;
        end
        dv_b_q = dv_b; fe_b_q = fe_b; dv_s_q = dv_s; fe_s_q = fe_s;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one line level for n clock edges; called just after a rising edge.
    task automatic drive(input bit big, input logic v, input int n);
        if (big) rx_b = v; else rx_s = v;
        repeat (n) @(posedge sys_clk);
    endtask

    task automatic send_frame(input bit big, input logic [7:0] b, input logic stop,
                              output longint t0);
        int div;
        div = big ? DIV_B : DIV_S;
        t0 = $time;
        drive(big, 1'b0, div);
        for (int i = 0; i < 8; i++) drive(big, b[i], div);
        drive(big, stop, div);
    endtask

    task automatic sample_mid();
        @(negedge sys_clk);
        @(posedge sys_clk);
    endtask

    initial begin
        longint tb0, ts0;
        int nv0;
        rst_b = 1'b1; rst_s = 1'b1; rx_b = 1'b1; rx_s = 1'b1;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_dout_b", {24'd0, dout_b}, 32'h00);
        chk("rst_dv_b",   {31'd0, dv_b},   32'h0);
        chk("rst_fe_b",   {31'd0, fe_b},   32'h0);
        chk("rst_busy_b", {31'd0, busy_b}, 32'h0);
        chk("rst_dout_s", {24'd0, dout_s}, 32'h00);
        chk("rst_busy_s", {31'd0, busy_s}, 32'h0);
        rst_b = 1'b0; rst_s = 1'b0;
        repeat (20000) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("idle_nv_b",  nv_b,  0);
        chk("idle_nfe_b", nfe_b, 0);
        chk("idle_nv_s",  nv_s,  0);
        chk("idle_nfe_s", nfe_s, 0);
        chk("idle_busy_b", {31'd0, busy_b}, 32'h0);
        @(posedge sys_clk);

        fork
            begin : big_side
                send_frame(1'b1, 8'hA5, 1'b1, tb0);
                drive(1'b1, 1'b1, DIV_B);
                sample_mid();
                chk("a5_nv",   nv_b, 1);
                chk("a5_data", {24'd0, dout_b}, 32'hA5);
                chk("a5_nfe",  nfe_b, 0);
                // 2 + CLK_DIV/2 + 9*CLK_DIV + 1 = 49479, +/-1 allowed
                chk("a5_lat", {31'd0, ((t_dv_b - tb0 - PER/2) / PER) inside {[49478:49480]}}, 32'h1);
                drive(1'b1, 1'b0, 1000);
                drive(1'b1, 1'b1, 3000);
                sample_mid();
                chk("glitch_nv_b",   nv_b,  1);
                chk("glitch_nfe_b",  nfe_b, 0);
                chk("glitch_busy_b", {31'd0, busy_b}, 32'h0);
            end
            begin : small_side
                // back-to-back 00, FF, 3C
                send_frame(1'b0, 8'h00, 1'b1, ts0);
                send_frame(1'b0, 8'hFF, 1'b1, ts0);
                send_frame(1'b0, 8'h3C, 1'b1, ts0);
                drive(1'b0, 1'b1, 3 * DIV_S);
                sample_mid();
                chk("b2b_nv", nv_s, 3);
                if (q_s.size() == 3) begin
                    chk("b2b_0", {24'd0, q_s[0]}, 32'h00);
                    chk("b2b_1", {24'd0, q_s[1]}, 32'hFF);
                    chk("b2b_2", {24'd0, q_s[2]}, 32'h3C);
                end
                chk("b2b_nfe", nfe_s, 0);
                // short low pulse, under half a bit
                drive(1'b0, 1'b0, 5);
                drive(1'b0, 1'b1, 40);
                sample_mid();
                chk("glitch_nv_s",   nv_s,  3);
                chk("glitch_nfe_s",  nfe_s, 0);
                chk("glitch_busy_s", {31'd0, busy_s}, 32'h0);
                // 5A with low stop bit, line held low 3 more bit times
                send_frame(1'b0, 8'h5A, 1'b0, ts0);
                drive(1'b0, 1'b0, 3 * DIV_S);
                sample_mid();
                chk("brk_nfe",  nfe_s, 1);
                chk("brk_busy", {31'd0, busy_s}, 32'h1);
                chk("brk_dout", {24'd0, dout_s}, 32'h3C);
                chk("brk_nv",   nv_s, 3);
                drive(1'b0, 1'b1, 4);
                sample_mid();
                chk("brk_exit_busy", {31'd0, busy_s}, 32'h0);
                chk("brk_exit_nfe",  nfe_s, 1);
                // reset during data bits of 0x81
                drive(1'b0, 1'b0, DIV_S);
                drive(1'b0, 1'b1, DIV_S);
                drive(1'b0, 1'b0, DIV_S / 2);
                rst_s = 1'b1;
                drive(1'b0, 1'b1, 3);
                sample_mid();
                chk("mrst_dout", {24'd0, dout_s}, 32'h00);
                chk("mrst_busy", {31'd0, busy_s}, 32'h0);
                rst_s = 1'b0;
                drive(1'b0, 1'b1, 2 * DIV_S);
                nv0 = nv_s;
                send_frame(1'b0, 8'h42, 1'b1, ts0);
                drive(1'b0, 1'b1, 2 * DIV_S);
                sample_mid();
                chk("post_nv",   nv_s - nv0, 1);
                chk("post_dout", {24'd0, dout_s}, 32'h42);
                chk("post_nfe",  nfe_s, 1);
                // 2 + 8 + 9*16 + 1 = 155, +/-1 allowed
                chk("post_lat", {31'd0, ((t_dv_s - ts0 - PER/2) / PER) inside {[154:156]}}, 32'h1);
            end
        join

        chk("pulse_excl",  both_cnt, 0);
        chk("pulse_width", wide_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
